// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter / fetch stage.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'd0,
    PC_BR   = 2'd1,
    PC_JALR = 2'd2,
    PC_RSV  = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    TRAP = 2'd3
  } fetch_state_e;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection and target alignment check.
module pc_next_logic
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  pc_src_e         pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] seq_target;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jr_sum;
  logic [XLEN-1:0] jr_target;

  assign seq_target = pc + XLEN'(PC_STEP);
  assign br_target  = pc + imm;
  assign jr_sum     = rs1_data + imm;
  assign jr_target  = {jr_sum[XLEN-1:1], 1'b0};

  always_comb begin
    next_pc = seq_target;
    case (pc_src)
      PC_BR:   next_pc = br_target;
      PC_JALR: next_pc = jr_target;
      default: next_pc = seq_target;
    endcase
  end

  // JALR already has bit 0 cleared, so a single two-bit check covers every source.
  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, BOOT/RUN/HALT/TRAP control and sticky trap capture.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            halt,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            trap,
  output logic [XLEN-1:0] trap_target,
  output logic [1:0]      state
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tt_q, tt_d;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  pc_next_logic #(.XLEN(XLEN)) u_next (
    .pc         (pc_q),
    .pc_src     (pc_src_e'(pc_src)),
    .imm        (imm),
    .rs1_data   (rs1_data),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tt_q    <= tt_d;
    end
  end

  // RUN priority: halt, then stall (which also suppresses the alignment check), then trap.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tt_d    = tt_q;
    case (state_q)
      BOOT: state_d = halt ? HALT : RUN;
      RUN: begin
        if (halt) begin
          state_d = HALT;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (misaligned) begin
          state_d = TRAP;
          tt_d    = next_pc;
        end else begin
          pc_d = next_pc;
        end
      end
      default: state_d = state_q;
    endcase
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(PC_STEP);
  assign fetch_valid = (state_q == RUN);
  assign trap        = (state_q == TRAP);
  assign trap_target = tt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Table-driven bench for pc_fetch_unit with a scoreboard of expected post-edge values.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        halt;
  logic [1:0]  pc_src;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        trap;
  logic [31:0] trap_target;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        halt;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] e_pc;
    logic [1:0]  e_st;
    logic        e_trap;
    logic [31:0] e_tt;
  } vec_t;

  vec_t tbl[$];
  logic [66:0] exp_q[$];

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .halt        (halt),
    .pc_src      (pc_src),
    .imm         (imm),
    .rs1_data    (rs1_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .trap        (trap),
    .trap_target (trap_target),
    .state       (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " pc"}, pc, 32'h0);
    chk({tag, " pc_plus4"}, pc_plus4, 32'h4);
    chk({tag, " state"}, 32'(state), 32'd0);
    chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'd0);
    chk({tag, " trap"}, 32'(trap), 32'd0);
    chk({tag, " trap_target"}, trap_target, 32'h0);
  endtask

  // Mid-cycle asynchronous reset pulse, entered at a falling edge.
  task automatic reset_pulse(input int idx);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals($sformatf("v%0d async reset", idx));
    #1 rst_n = 1'b1;
    #1 chk($sformatf("v%0d boot state", idx), 32'(state), 32'd0);
  endtask

  function automatic vec_t mk(logic r, logic s, logic h, logic [1:0] src, logic [31:0] im,
                              logic [31:0] rs, logic [31:0] epc, logic [1:0] est,
                              logic etr, logic [31:0] ett);
    vec_t v;
    v.rst = r; v.stall = s; v.halt = h; v.src = src; v.imm = im; v.rs1 = rs;
    v.e_pc = epc; v.e_st = est; v.e_trap = etr; v.e_tt = ett;
    return v;
  endfunction

  // driver: apply one vector and queue what must be visible after the next edge
  task automatic drive(input vec_t v, input int idx);
    stall    = v.stall;
    halt     = v.halt;
    pc_src   = v.src;
    imm      = v.imm;
    rs1_data = v.rs1;
    if (v.rst) reset_pulse(idx);
    exp_q.push_back({v.e_pc, v.e_tt, v.e_st, v.e_trap});
  endtask

  // scoreboard: pop and compare
  task automatic compare(input int idx);
    logic [66:0] e;
    logic [31:0] e_pc, e_tt;
    logic [1:0]  e_st;
    logic        e_tr;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL v%0d scoreboard: got empty queue want entry", idx);
      return;
    end
    e = exp_q.pop_front();
    {e_pc, e_tt, e_st, e_tr} = e;
    chk($sformatf("v%0d pc", idx), pc, e_pc);
    chk($sformatf("v%0d pc_plus4", idx), pc_plus4, e_pc + 32'd4);
    chk($sformatf("v%0d state", idx), 32'(state), 32'(e_st));
    chk($sformatf("v%0d fetch_valid", idx), 32'(fetch_valid), 32'(e_st == 2'd1));
    chk($sformatf("v%0d trap", idx), 32'(trap), 32'(e_tr));
    chk($sformatf("v%0d trap_target", idx), trap_target, e_tt);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; halt = 1'b0; pc_src = 2'd0; imm = '0; rs1_data = '0;

    // free run, branches, JALR, stalls
    tbl.push_back(mk(0,0,0,0, 32'h0,        32'h0,   32'h0,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,        32'h0,   32'h4,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,        32'h0,   32'h8,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,1, 32'hFFFFFFF8, 32'h0,   32'h0,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,        32'h0,   32'h4,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,        32'h0,   32'h8,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,1, 32'h10,       32'h0,   32'h18,       1,0,32'h0));
    tbl.push_back(mk(0,0,0,1, 32'hFFFFFFF4, 32'h0,   32'hC,        1,0,32'h0));
    tbl.push_back(mk(0,1,0,0, 32'h0,        32'h0,   32'hC,        1,0,32'h0));
    tbl.push_back(mk(0,1,0,0, 32'h0,        32'h0,   32'hC,        1,0,32'h0));
    tbl.push_back(mk(0,1,0,0, 32'h0,        32'h0,   32'hC,        1,0,32'h0));
    tbl.push_back(mk(0,1,0,1, 32'h2,        32'h0,   32'hC,        1,0,32'h0));
    tbl.push_back(mk(0,1,0,2, 32'h2,        32'h101, 32'hC,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,        32'h0,   32'h10,       1,0,32'h0));
    tbl.push_back(mk(0,0,0,2, 32'h3,        32'h21,  32'h24,       1,0,32'h0));
    tbl.push_back(mk(0,0,0,1, 32'hFFFFFFDC, 32'h0,   32'h0,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,1, 32'hFFFFFFFC, 32'h0,   32'hFFFFFFFC, 1,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,        32'h0,   32'h0,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,        32'h0,   32'h4,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,3, 32'h40,       32'h0,   32'h8,        1,0,32'h0));
    // halt beats stall; HALT ignores all inputs
    tbl.push_back(mk(0,1,1,0, 32'h0,        32'h0,   32'h8,        2,0,32'h0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                       2'($urandom_range(0,3)), 32'($urandom_range(0,255)) | 32'h1,
                       32'($urandom_range(0,255)), 32'h8, 2, 0, 32'h0));
    // async reset mid-cycle, run to 16, halt there for five cycles
    tbl.push_back(mk(1,0,0,0, 32'h0,        32'h0,   32'h0,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,        32'h0,   32'h4,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,        32'h0,   32'h8,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,        32'h0,   32'hC,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,        32'h0,   32'h10,       1,0,32'h0));
    tbl.push_back(mk(0,0,1,0, 32'h0,        32'h0,   32'h10,       2,0,32'h0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,0, 32'h0,      32'h0,   32'h10,       2,0,32'h0));
    // JALR misaligned trap, sticky
    tbl.push_back(mk(1,0,0,0, 32'h0,        32'h0,   32'h0,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,2, 32'h2,        32'h101, 32'h0,        3,1,32'h102));
    tbl.push_back(mk(0,0,0,0, 32'h0,        32'h0,   32'h0,        3,1,32'h102));
    tbl.push_back(mk(0,0,0,1, 32'h6,        32'h0,   32'h0,        3,1,32'h102));
    // halt during BOOT
    tbl.push_back(mk(1,0,1,0, 32'h0,        32'h0,   32'h0,        2,0,32'h0));
    // stalled misaligned branch traps only once stall drops
    tbl.push_back(mk(1,0,0,0, 32'h0,        32'h0,   32'h0,        1,0,32'h0));
    tbl.push_back(mk(0,1,0,1, 32'h6,        32'h0,   32'h0,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,1, 32'h6,        32'h0,   32'h0,        3,1,32'h6));
    // branch ignored in BOOT; odd branch target traps on bit 0
    tbl.push_back(mk(1,0,0,1, 32'h100,      32'h0,   32'h0,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,1, 32'h100,      32'h0,   32'h100,      1,0,32'h0));
    tbl.push_back(mk(0,0,0,1, 32'h1,        32'h0,   32'h100,      3,1,32'h101));
    // JALR clears bit 0; JALR sum wraps and misaligns on bit 1
    tbl.push_back(mk(1,0,0,0, 32'h0,        32'h0,   32'h0,        1,0,32'h0));
    tbl.push_back(mk(0,0,0,2, 32'h1,        32'h200, 32'h200,      1,0,32'h0));
    tbl.push_back(mk(0,0,0,2, 32'h7,        32'hFFFFFFFF, 32'h200, 3,1,32'h6));

    #2 chk_reset_vals("power-on reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("boot pc", pc, 32'h0);
    chk("boot state", 32'(state), 32'd0);
    chk("boot fetch_valid", 32'(fetch_valid), 32'd0);

    foreach (tbl[i]) begin
      drive(tbl[i], i);
      @(negedge clk);
      compare(i);
    end

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
